pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage branch-predicted RV32I pipeline. Consumes decode-stage register usage, EX-stage branch outcome/prediction and JALR redirect, and data-memory handshake. Produces per-stage stall and flush controls plus saturating performance counters. Replaces per-instruction flush generation in decode with one arbitrated source of pipeline control.

## Interface
- CNT_W, 32: width of each performance counter.
- MEM_TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before timeout (1..255).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_is_load  in  1  EX instruction is a load.
- ex_br_valid  in  1  EX holds a conditional branch.
- ex_br_pred, ex_br_actual  in  1 each  predicted and resolved taken.
- ex_jalr  in  1  EX holds a JALR; its target was unknown at fetch.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes access this cycle.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the register.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble.
- pc_redirect  out  1  PC takes EX-computed target (or fall-through on not-taken mispredict).
- mem_timeout_err  out  1  sticky memory-timeout flag.
- perf_branches, perf_mispredicts, perf_stall_cycles  out  CNT_W each  counters.

## Operation
- States: RUN, MEM_WAIT. A 8-bit wait counter `wcnt` runs only in MEM_WAIT.
- freeze = (mem_req & ~mem_ready & ~mem_timeout_err-this-cycle). In RUN, freeze moves state to MEM_WAIT, wcnt←1. In MEM_WAIT, mem_ready → RUN; else wcnt increments; when wcnt == MEM_TIMEOUT and ~mem_ready: mem_timeout_err←1 (sticky until rst), state→RUN, and that cycle is not frozen (access abandoned; mem_wb_flush=1).
- While freeze: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1; all other flushes and pc_redirect = 0. mem_timeout_err set → later mem_req never freezes.
- mispredict = ex_br_valid & (ex_br_pred ≠ ex_br_actual). redirect = mispredict | ex_jalr.
- Not frozen and redirect: pc_redirect = 1, if_id_flush = 1, id_ex_flush = 1; no stalls. Redirect while frozen is held by the stalled EX register and asserted in the first unfrozen cycle.
- load_use = ex_is_load & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Not frozen, no redirect, load_use: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1.
- Priority: freeze > redirect > load_use > none.
- Counters update on unfrozen cycles only, saturate at 2^CNT_W−1: perf_branches += ex_br_valid; perf_mispredicts += mispredict; perf_stall_cycles += load_use-stall. Frozen cycles increment perf_stall_cycles instead (also saturating).

## Timing
- All stall/flush/redirect outputs combinational from inputs and current state; same-cycle response.
- State, wcnt, mem_timeout_err, counters register on rising clk.
- Reset: state=RUN, wcnt=0, mem_timeout_err=0, counters=0; with all inputs 0 every output is 0. rst during MEM_WAIT returns to RUN next edge; counters clear, no pending redirect retained.
- Load-use costs exactly 1 bubble; mispredict/JALR cost 2 flushed slots; memory wait of N cycles adds N frozen cycles.
- Timeout: freeze lasts exactly MEM_TIMEOUT cycles before forced release.

## Test plan
- Reset then idle 5 cycles -> all outputs 0, counters 0.
- ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> same cycle pc_stall=if_id_stall=id_ex_flush=1; perf_stall_cycles=1 next edge; ex_rd=0 variant -> no stall.
- ex_br_valid=1, pred=1, actual=0 simultaneous with load_use -> pc_redirect=if_id_flush=id_ex_flush=1, no stalls; perf_branches=1, perf_mispredicts=1.
- mem_req=1, mem_ready low 3 cycles then high, mispredict held in EX -> 3 frozen cycles (all stalls, mem_wb_flush), redirect only in 4th cycle; perf_stall_cycles=3.
- mem_req=1, mem_ready=0 forever, MEM_TIMEOUT=4 -> freeze 4 cycles, mem_timeout_err=1, subsequent mem_req no stall; rst clears error.
- CNT_W=4, 20 mispredicting branches -> perf_branches and perf_mispredicts stick at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: decode/EX/MEM status
// inward, per-stage stall/flush/redirect controls outward.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       ex_br_valid;
  logic       ex_br_pred;
  logic       ex_br_actual;
  logic       ex_jalr;
  // Memory handshake: an access is outstanding in every cycle mem_req is high.
  // It completes in the cycle where mem_req and mem_ready are both high.
  // mem_ready without mem_req carries no meaning.
  logic       mem_req;
  logic       mem_ready;
  logic       pc_stall;
  logic       if_id_stall;
  logic       id_ex_stall;
  logic       ex_mem_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mem_wb_flush;
  logic       pc_redirect;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_br_valid, ex_br_pred, ex_br_actual, ex_jalr, mem_req, mem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_br_valid, ex_br_pred, ex_br_actual, ex_jalr, mem_req, mem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: memory freeze > redirect > load-use, with a
// bounded memory wait and saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  pipeline_hazard_ctrl_if.slave     pif,
  output logic                      mem_timeout_err,
  output logic [CNT_W-1:0]          perf_branches,
  output logic [CNT_W-1:0]          perf_mispredicts,
  output logic [CNT_W-1:0]          perf_stall_cycles,
  output logic                      dbg_state
);
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0]       TMO     = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       mispredict, redirect, load_use, lu_stall;
  logic       timeout_now, freeze;

  assign mispredict = pif.ex_br_valid & (pif.ex_br_pred ^ pif.ex_br_actual);
  assign redirect   = mispredict | pif.ex_jalr;
  assign load_use   = pif.ex_is_load & (pif.ex_rd != 5'd0) &
                      ((pif.id_use_rs1 & (pif.id_rs1 == pif.ex_rd)) |
                       (pif.id_use_rs2 & (pif.id_rs2 == pif.ex_rd)));

  // The timeout cycle itself is released so the abandoned access drains as a bubble.
  assign timeout_now = (state == MEM_WAIT) & pif.mem_req & ~pif.mem_ready & (wcnt == TMO);
  assign freeze      = pif.mem_req & ~pif.mem_ready & ~mem_timeout_err & ~timeout_now;
  assign lu_stall    = ~freeze & ~redirect & load_use;
  assign dbg_state   = (state == MEM_WAIT);

  always_comb begin
    pif.pc_stall     = 1'b0;
    pif.if_id_stall  = 1'b0;
    pif.id_ex_stall  = 1'b0;
    pif.ex_mem_stall = 1'b0;
    pif.if_id_flush  = 1'b0;
    pif.id_ex_flush  = 1'b0;
    pif.mem_wb_flush = 1'b0;
    pif.pc_redirect  = 1'b0;
    if (freeze) begin
      pif.pc_stall     = 1'b1;
      pif.if_id_stall  = 1'b1;
      pif.id_ex_stall  = 1'b1;
      pif.ex_mem_stall = 1'b1;
      pif.mem_wb_flush = 1'b1;
    end else begin
      pif.mem_wb_flush = timeout_now;
      if (redirect) begin
        pif.pc_redirect = 1'b1;
        pif.if_id_flush = 1'b1;
        pif.id_ex_flush = 1'b1;
      end else if (load_use) begin
        pif.pc_stall    = 1'b1;
        pif.if_id_stall = 1'b1;
        pif.id_ex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt = MEM_WAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          wcnt_nxt = wcnt + 8'd1;
        end else begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RUN;
      wcnt              <= 8'd0;
      mem_timeout_err   <= 1'b0;
      perf_branches     <= '0;
      perf_mispredicts  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      state           <= state_nxt;
      wcnt            <= wcnt_nxt;
      mem_timeout_err <= mem_timeout_err | timeout_now;
      if (freeze) begin
        perf_stall_cycles <= sat_inc(perf_stall_cycles, 1'b1);
      end else begin
        perf_branches     <= sat_inc(perf_branches, pif.ex_br_valid);
        perf_mispredicts  <= sat_inc(perf_mispredicts, mispredict);
        perf_stall_cycles <= sat_inc(perf_stall_cycles, lu_stall);
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios plus random traffic,
// checked by a scoreboard fed from a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int W           = 9 + 3 * CNT_W;
  localparam int CMAX        = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] ex_rd;
    logic       is_load;
    logic       br_valid;
    logic       pred;
    logic       actual;
    logic       jalr;
    logic       mem_req;
    logic       mem_ready;
  } stim_t;

  logic clk;
  logic rst;
  logic mem_timeout_err;
  logic dbg_state;
  logic [CNT_W-1:0] perf_branches, perf_mispredicts, perf_stall_cycles;

  pipeline_hazard_ctrl_if pif ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .pif               (pif),
    .mem_timeout_err   (mem_timeout_err),
    .perf_branches     (perf_branches),
    .perf_mispredicts  (perf_mispredicts),
    .perf_stall_cycles (perf_stall_cycles),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  stim_t s;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // model state: consecutive frozen cycles so far, sticky error, counters
  int m_frozen = 0;
  bit m_err    = 1'b0;
  int m_br = 0, m_mis = 0, m_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  function automatic stim_t idle();
    stim_t z;
    z = '0;
    return z;
  endfunction

  // driver: apply one cycle of stimulus, push expected outputs, advance model
  task automatic step();
    bit mis, redir, lu, tmo, fr;
    logic [7:0] ctrl;
    @(posedge clk);
    #1;
    rst              = s.rst;
    pif.id_rs1       = s.rs1;
    pif.id_rs2       = s.rs2;
    pif.id_use_rs1   = s.use1;
    pif.id_use_rs2   = s.use2;
    pif.ex_rd        = s.ex_rd;
    pif.ex_is_load   = s.is_load;
    pif.ex_br_valid  = s.br_valid;
    pif.ex_br_pred   = s.pred;
    pif.ex_br_actual = s.actual;
    pif.ex_jalr      = s.jalr;
    pif.mem_req      = s.mem_req;
    pif.mem_ready    = s.mem_ready;

    mis   = s.br_valid && (s.pred != s.actual);
    redir = mis || s.jalr;
    lu    = s.is_load && (s.ex_rd != 0) &&
            ((s.use1 && s.rs1 == s.ex_rd) || (s.use2 && s.rs2 == s.ex_rd));
    tmo   = s.mem_req && !s.mem_ready && !m_err && (m_frozen == MEM_TIMEOUT);
    fr    = s.mem_req && !s.mem_ready && !m_err && !tmo;
    // order: pc_stall if_id_stall id_ex_stall ex_mem_stall if_id_flush id_ex_flush mem_wb_flush pc_redirect
    if (fr)         ctrl = 8'b1111_0010;
    else if (redir) ctrl = {4'b0000, 1'b1, 1'b1, tmo, 1'b1};
    else if (lu)    ctrl = {4'b1100, 1'b0, 1'b1, tmo, 1'b0};
    else            ctrl = {6'b0, tmo, 1'b0};
    exp_q.push_back({ctrl, m_err, CNT_W'(m_br), CNT_W'(m_mis), CNT_W'(m_stall)});

    if (s.rst) begin
      m_frozen = 0; m_err = 1'b0; m_br = 0; m_mis = 0; m_stall = 0;
    end else begin
      if (fr) begin
        m_stall = sat(m_stall);
      end else begin
        if (s.br_valid)       m_br    = sat(m_br);
        if (mis)              m_mis   = sat(m_mis);
        if (lu && !redir)     m_stall = sat(m_stall);
      end
      if (tmo) m_err = 1'b1;
      m_frozen = fr ? m_frozen + 1 : 0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      s = idle();
      step();
    end
  endtask

  task automatic do_reset();
    s = idle();
    s.rst = 1'b1;
    step();
    step();
  endtask

  // scoreboard monitor: combinational outputs settle mid-cycle, compare at negedge
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctrl", {24'b0, pif.pc_stall, pif.if_id_stall, pif.id_ex_stall, pif.ex_mem_stall,
                       pif.if_id_flush, pif.id_ex_flush, pif.mem_wb_flush, pif.pc_redirect},
              {24'b0, e[W-1 -: 8]});
        check("timeout_err", {31'b0, mem_timeout_err}, {31'b0, e[3*CNT_W]});
        check("perf_branches", 32'(perf_branches), 32'(e[3*CNT_W-1 -: CNT_W]));
        check("perf_mispredicts", 32'(perf_mispredicts), 32'(e[2*CNT_W-1 -: CNT_W]));
        check("perf_stall_cycles", 32'(perf_stall_cycles), 32'(e[CNT_W-1 -: CNT_W]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    pif.id_rs1 = '0; pif.id_rs2 = '0; pif.id_use_rs1 = 0; pif.id_use_rs2 = 0;
    pif.ex_rd = '0; pif.ex_is_load = 0; pif.ex_br_valid = 0; pif.ex_br_pred = 0;
    pif.ex_br_actual = 0; pif.ex_jalr = 0; pif.mem_req = 0; pif.mem_ready = 0;

    do_reset();
    idle_cycles(5);

    // load-use on rs2, then the x0 variant that must not stall
    s = idle(); s.is_load = 1; s.ex_rd = 5'd5; s.rs2 = 5'd5; s.use2 = 1; step();
    s = idle(); s.is_load = 1; s.ex_rd = 5'd0; s.rs2 = 5'd0; s.use2 = 1; step();
    s = idle(); s.is_load = 1; s.ex_rd = 5'd7; s.rs1 = 5'd7; s.use1 = 0; step();
    idle_cycles(1);

    // mispredict beats a simultaneous load-use
    s = idle(); s.is_load = 1; s.ex_rd = 5'd5; s.rs1 = 5'd5; s.use1 = 1;
    s.br_valid = 1; s.pred = 1; s.actual = 0; step();
    s = idle(); s.jalr = 1; step();
    idle_cycles(1);

    // three-cycle memory wait with a mispredict held in EX
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.mem_req = 1; s.mem_ready = (i == 3);
      s.br_valid = 1; s.pred = 0; s.actual = 1; step();
    end
    idle_cycles(2);

    // memory never answers: forced release, then requests stop freezing
    do_reset();
    for (int i = 0; i < 8; i++) begin
      s = idle(); s.mem_req = 1; s.mem_ready = 0; step();
    end
    s = idle(); s.mem_req = 1; s.is_load = 1; s.ex_rd = 5'd3; s.rs1 = 5'd3; s.use1 = 1; step();
    @(negedge clk); #1;
    check("err_after_timeout", {31'b0, mem_timeout_err}, 32'd1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.mem_req = 1; s.mem_ready = (i == 2); step();
    end

    // counter saturation with 20 mispredicting branches
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s = idle(); s.br_valid = 1; s.pred = i[0]; s.actual = ~i[0]; step();
    end
    idle_cycles(1);
    @(negedge clk); #1;
    check("branches_saturated", 32'(perf_branches), 32'd15);
    check("mispredicts_saturated", 32'(perf_mispredicts), 32'd15);

    // random traffic; small register range keeps hazards frequent
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      s = idle();
      s.rst       = ($urandom_range(0, 49) == 0);
      s.rs1       = 5'($urandom_range(0, 3));
      s.rs2       = 5'($urandom_range(0, 3));
      s.use1      = 1'($urandom_range(0, 1));
      s.use2      = 1'($urandom_range(0, 1));
      s.ex_rd     = 5'($urandom_range(0, 3));
      s.is_load   = 1'($urandom_range(0, 1));
      s.br_valid  = ($urandom_range(0, 2) == 0);
      s.pred      = 1'($urandom_range(0, 1));
      s.actual    = 1'($urandom_range(0, 1));
      s.jalr      = ($urandom_range(0, 9) == 0);
      s.mem_req   = ($urandom_range(0, 2) == 0) || (m_frozen > 0 && $urandom_range(0, 3) != 0);
      s.mem_ready = ($urandom_range(0, 3) == 0);
      step();
    end

    idle_cycles(1);
    @(posedge clk);
    @(negedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // overall time limit so the run always ends with a summary
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
